// File: rtl/plic_gateway_claim.sv
// -----------------------------------------------------------------------------
// plic_gateway_claim
//
// Level-sensitive interrupt gateway and claim arbiter for up to 32 sources.
// Each asserted source level is turned into one pending request. A request
// moves to in-flight when it is loaded into the claim slot. It stays in flight
// until software completes it. The claim slot is a registered valid/ready
// port. When the slot is free it loads the lowest-numbered source that is both
// enabled and pending.
//
// Parameters
//   NSRC : number of sources (1..32). Source i is reported as claim ID i+1.
//   IDW  : ID width. 2**IDW must exceed NSRC.
//
// Ports
//   clock             : single clock for all state
//   reset             : synchronous, active-high reset
//   io_src            : sampled source levels, 1 = asserted
//   io_enable         : per-source enable (claim selection only)
//   io_claim_valid    : claim slot holds a valid ID
//   io_claim_ready    : consumer accepts the claim slot
//   io_claim_id       : claimed ID (1..NSRC), 0 while io_claim_valid = 0
//   io_complete_valid : completion strobe
//   io_complete_id    : ID being completed
//   io_pending        : pending register (status readback)
//   io_inflight       : in-flight register (status readback)
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module plic_gateway_claim #(
  parameter int NSRC = 32,
  parameter int IDW  = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] io_src,
  input  logic [NSRC-1:0] io_enable,
  output logic            io_claim_valid,
  input  logic            io_claim_ready,
  output logic [IDW-1:0]  io_claim_id,
  input  logic            io_complete_valid,
  input  logic [IDW-1:0]  io_complete_id,
  output logic [NSRC-1:0] io_pending,
  output logic [NSRC-1:0] io_inflight
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] inflight_q;
  logic            claim_valid_q;
  logic [IDW-1:0]  claim_id_q;

  // ---------------------------------------------------------------------------
  // Combinational next-state terms
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] request;      // enabled and pending
  logic            sel_found;
  logic [IDW-1:0]  sel;          // zero-based index of the winning source
  logic [NSRC-1:0] load_mask;    // one-hot of the source loaded into the slot
  logic [NSRC-1:0] done_mask;    // one-hot of an accepted completion
  logic [NSRC-1:0] set_mask;     // gateway sets this edge
  logic            slot_free;
  logic            load;

  assign request   = pending_q & io_enable;
  assign slot_free = !claim_valid_q || io_claim_ready;

  // Lowest-index priority encoder. The loop scans downward so the last match,
  // which is the lowest index, takes effect.
  // NOTE: every variable written in this block gets a default first. Without
  // the default, a path that does not assign it would infer a latch.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (request[i]) begin
        sel_found = 1'b1;
        sel       = IDW'(i);
      end
    end
  end

  assign load = slot_free && sel_found;

  always_comb begin
    load_mask = '0;
    if (load) begin
      load_mask[sel] = 1'b1;
    end
  end

  // A completion counts only when it names a source that is actually in
  // flight. The IDs compared are 1..NSRC only, so ID 0 and any ID past NSRC
  // match nothing and are dropped without indexing out of range.
  always_comb begin
    done_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      done_mask[i] = io_complete_valid && (io_complete_id == IDW'(i + 1)) &&
                     inflight_q[i];
    end
  end

  // The gateway only fires for an idle source (neither pending nor in flight).
  // A source completing this cycle is still in flight in the current state, so
  // it cannot re-pend until the following edge. That is why the completion
  // wins over a simultaneous gateway set.
  assign set_mask = io_src & ~pending_q & ~inflight_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q     <= '0;
      inflight_q    <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      // Loading clears the winning pending bit. A level drop never clears a
      // pending bit, because the request is latched.
      pending_q  <= (pending_q | set_mask) & ~load_mask;
      // load_mask needs pending=1, which implies inflight=0. done_mask needs
      // inflight=1. The two masks are therefore never set for the same source.
      inflight_q <= (inflight_q & ~done_mask) | load_mask;

      // Slot holds while it is valid and not accepted. Once it frees, it
      // either reloads with the new winner or goes empty with ID 0.
      if (slot_free) begin
        claim_valid_q <= sel_found;
        claim_id_q    <= sel_found ? sel + IDW'(1) : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign io_claim_valid = claim_valid_q;
  assign io_claim_id    = claim_id_q;
  assign io_pending     = pending_q;
  assign io_inflight    = inflight_q;

endmodule

// File: tb/tb_plic_gateway_claim.sv
// -----------------------------------------------------------------------------
// tb_plic_gateway_claim
//
// Directed self-checking bench for plic_gateway_claim (NSRC=32, IDW=6).
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_plic_gateway_claim;

  localparam int NSRC = 32;
  localparam int IDW  = 6;

  logic            clock;
  logic            reset;
  logic [NSRC-1:0] io_src;
  logic [NSRC-1:0] io_enable;
  logic            io_claim_valid;
  logic            io_claim_ready;
  logic [IDW-1:0]  io_claim_id;
  logic            io_complete_valid;
  logic [IDW-1:0]  io_complete_id;
  logic [NSRC-1:0] io_pending;
  logic [NSRC-1:0] io_inflight;

  int tests_run = 0;
  int tests_failed = 0;

  plic_gateway_claim #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_src            (io_src),
    .io_enable         (io_enable),
    .io_claim_valid    (io_claim_valid),
    .io_claim_ready    (io_claim_ready),
    .io_claim_id       (io_claim_id),
    .io_complete_valid (io_complete_valid),
    .io_complete_id    (io_complete_id),
    .io_pending        (io_pending),
    .io_inflight       (io_inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_slot(input string tag, input logic valid,
                            input logic [IDW-1:0] id);
    check({tag, ".valid"}, 64'(io_claim_valid), 64'(valid));
    check({tag, ".id"},    64'(io_claim_id),    64'(id));
  endtask

  task automatic do_reset();
    io_src            = '0;
    io_enable         = '0;
    io_claim_ready    = 1'b0;
    io_complete_valid = 1'b0;
    io_complete_id    = '0;
    reset             = 1'b1;
    tick();
    reset             = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    io_src            = '0;
    io_enable         = '0;
    io_claim_ready    = 1'b0;
    io_complete_valid = 1'b0;
    io_complete_id    = '0;
    @(negedge clock);

    // ---- 1. Reset with everything asserted --------------------------------
    io_src         = '1;
    io_enable      = '1;
    io_claim_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_slot("rst.slot", 1'b0, 6'd0);
      check("rst.pending",  64'(io_pending),  64'h0);
      check("rst.inflight", 64'(io_inflight), 64'h0);
    end
    reset = 1'b0;
    tick();
    check("rst.edge1.pending", 64'(io_pending), 64'hFFFF_FFFF);
    check_slot("rst.edge1", 1'b0, 6'd0);
    tick();
    check_slot("rst.edge2", 1'b1, 6'd1);

    // ---- 2. Single source lifecycle ---------------------------------------
    do_reset();
    io_enable      = '1;
    io_claim_ready = 1'b1;
    io_src         = 32'h20;
    tick();
    check("life.pend", 64'(io_pending), 64'h20);
    check_slot("life.e1", 1'b0, 6'd0);
    tick();
    check_slot("life.claim", 1'b1, 6'd6);
    check("life.inflight", 64'(io_inflight), 64'h20);
    check("life.pend0",    64'(io_pending),  64'h0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_slot("life.noreclaim", 1'b0, 6'd0);
    end
    check("life.inflight_held", 64'(io_inflight), 64'h20);
    io_complete_valid = 1'b1;
    io_complete_id    = 6'd6;
    tick();
    io_complete_valid = 1'b0;
    // Completion wins over the gateway: pending stays 0 on the completing edge.
    check("life.done.inflight", 64'(io_inflight), 64'h0);
    check("life.done.pend",     64'(io_pending),  64'h0);
    tick();
    check("life.repend", 64'(io_pending), 64'h20);
    check_slot("life.repend", 1'b0, 6'd0);
    tick();
    check_slot("life.reclaim", 1'b1, 6'd6);

    // ---- 3. Priority ordering ---------------------------------------------
    do_reset();
    io_enable      = '1;
    io_claim_ready = 1'b1;
    io_src         = 32'h8000_0009;
    tick();
    io_src = '0;
    check("prio.pend", 64'(io_pending), 64'h8000_0009);
    tick();
    check_slot("prio.c1", 1'b1, 6'd1);
    tick();
    check_slot("prio.c2", 1'b1, 6'd4);
    tick();
    check_slot("prio.c3", 1'b1, 6'd32);
    tick();
    check_slot("prio.empty", 1'b0, 6'd0);
    check("prio.inflight", 64'(io_inflight), 64'h8000_0009);

    // ---- 4. Backpressure ---------------------------------------------------
    do_reset();
    io_enable = '1;
    io_src    = 32'h10;
    tick();
    tick();
    check_slot("bp.load", 1'b1, 6'd5);
    io_src = 32'h11;
    tick();
    check("bp.pend_low", 64'(io_pending), 64'h1);
    check_slot("bp.hold0", 1'b1, 6'd5);
    for (int c = 0; c < 4; c++) begin
      tick();
      check_slot("bp.hold", 1'b1, 6'd5);
    end
    io_claim_ready = 1'b1;
    tick();
    check_slot("bp.next", 1'b1, 6'd1);
    tick();
    check_slot("bp.empty", 1'b0, 6'd0);
    check("bp.inflight", 64'(io_inflight), 64'h11);

    // ---- 5. Enable mask ----------------------------------------------------
    do_reset();
    io_enable      = ~32'h4;
    io_claim_ready = 1'b1;
    io_src         = 32'h4;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_slot("en.masked", 1'b0, 6'd0);
    end
    check("en.pend", 64'(io_pending), 64'h4);
    io_enable = '1;
    tick();
    check_slot("en.claim", 1'b1, 6'd3);

    // ---- 6. Illegal completes and reset mid-flight ------------------------
    do_reset();
    io_enable      = '1;
    io_claim_ready = 1'b1;
    io_src         = 32'h3;
    tick();
    io_src = '0;
    tick();
    check_slot("ill.c1", 1'b1, 6'd1);
    tick();
    check_slot("ill.c2", 1'b1, 6'd2);
    io_claim_ready = 1'b0;
    check("ill.inflight0", 64'(io_inflight), 64'h3);
    io_complete_valid = 1'b1;
    io_complete_id    = 6'd0;
    tick();
    check("ill.id0", 64'(io_inflight), 64'h3);
    io_complete_id = 6'd40;
    tick();
    check("ill.id40", 64'(io_inflight), 64'h3);
    io_complete_id = 6'd7;
    tick();
    check("ill.id7", 64'(io_inflight), 64'h3);
    io_complete_valid = 1'b0;
    check_slot("ill.slot_held", 1'b1, 6'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_slot("midrst", 1'b0, 6'd0);
    check("midrst.pending",  64'(io_pending),  64'h0);
    check("midrst.inflight", 64'(io_inflight), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
